uart_alu_ctrl: RTL and testbench

//  Frame sequencer between the UART receiver, the ALU and the UART transmitter.
//  - Collects three received bytes in order: operand A, operand B, opcode.
//  - Drives the ALU and latches its combinational result.
//  - Hands the result byte to the transmitter with a start/done handshake, then re-arms.

---
 rtl/uart_alu_ctrl_if.sv | 29 ++
 rtl/uart_alu_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the receiver, ALU and transmitter signals handled by the frame sequencer.
// The master modport is the sequencer; the slave modport is the UART/ALU side.
interface uart_alu_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               rx_done_tick;
    logic [NB_DATA-1:0] rx_data;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done_tick;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               busy;
    logic               overrun;
    logic               timeout_tick;

    modport master (
        input  rx_done_tick, rx_data, alu_result, tx_done_tick,
        output alu_a, alu_b, alu_op, tx_start, tx_data, busy, overrun, timeout_tick
    );

    modport slave (
        output rx_done_tick, rx_data, alu_result, tx_done_tick,
        input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, overrun, timeout_tick
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: collects operand A, operand B and opcode from the UART receiver,
// latches the ALU result and hands it to the transmitter. Optional RX_TIMEOUT_EN macro
// enables discarding of partial frames after TIMEOUT_CYCLES idle clocks.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           reset,
    uart_alu_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_alu_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_reg,   state_next;
    logic [NB_DATA-1:0] alu_a_reg,   alu_a_next;
    logic [NB_DATA-1:0] alu_b_reg,   alu_b_next;
    logic [NB_OP-1:0]   alu_op_reg,  alu_op_next;
    logic [NB_DATA-1:0] tx_data_reg, tx_data_next;
    logic               overrun_reg, overrun_next;
    logic               busy_w;

    assign busy_w = (state_reg == EXEC) || (state_reg == SEND) || (state_reg == WAIT_TX);

`ifdef RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             timeout_reg, timeout_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= WAIT_A;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_op_reg  <= '0;
            tx_data_reg <= '0;
            overrun_reg <= 1'b0;
`ifdef RX_TIMEOUT_EN
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            alu_a_reg   <= alu_a_next;
            alu_b_reg   <= alu_b_next;
            alu_op_reg  <= alu_op_next;
            tx_data_reg <= tx_data_next;
            overrun_reg <= overrun_next;
`ifdef RX_TIMEOUT_EN
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        alu_a_next   = alu_a_reg;
        alu_b_next   = alu_b_reg;
        alu_op_next  = alu_op_reg;
        tx_data_next = tx_data_reg;
        overrun_next = overrun_reg;
`ifdef RX_TIMEOUT_EN
        cnt_next     = '0;
        timeout_next = 1'b0;
`endif

        case (state_reg)
            WAIT_A: begin
                if (bus.rx_done_tick) begin
                    alu_a_next = bus.rx_data;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.rx_done_tick) begin
                    alu_b_next = bus.rx_data;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (bus.rx_done_tick) begin
                    alu_op_next = bus.rx_data[NB_OP-1:0];
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                // The ALU has had a full cycle to settle on the new operands.
                tx_data_next = bus.alu_result;
                state_next   = SEND;
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done_tick) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase

        // Bytes arriving while a result is in flight are dropped but remembered.
        if (bus.rx_done_tick && busy_w) begin
            overrun_next = 1'b1;
        end

`ifdef RX_TIMEOUT_EN
        if ((state_reg == WAIT_B) || (state_reg == WAIT_OP)) begin
            if (bus.rx_done_tick) begin
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Operands already captured are left in place; only the frame restarts.
                cnt_next     = '0;
                timeout_next = 1'b1;
                state_next   = WAIT_A;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
`endif
    end

    assign bus.alu_a    = alu_a_reg;
    assign bus.alu_b    = alu_b_reg;
    assign bus.alu_op   = alu_op_reg;
    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_start = (state_reg == SEND);
    assign bus.busy     = busy_w;
    assign bus.overrun  = overrun_reg;
`ifdef RX_TIMEOUT_EN
    assign bus.timeout_tick = timeout_reg;
`else
    assign bus.timeout_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed frames plus randomized frames checked
// against an arithmetic ALU reference; timeout scenario selected by RX_TIMEOUT_EN.
module tb_uart_alu_ctrl;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 100;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    logic overrun_exp = 1'b0;

    uart_alu_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: a reference of the opcode table, driven back into the DUT.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return 8'(a + b);
            6'h22:   return 8'(a - b);
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    always @(posedge clk) if (bus.tx_start) pulse_cnt <= pulse_cnt + 1;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data      = b;
        bus.rx_done_tick = 1'b1;
        @(negedge clk);
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        overrun_exp = 1'b0;
    endtask

    // Sends B and opcode (A already accepted), then checks result, handshake and release.
    // mode 0: plain tx_done; 1: extra byte in WAIT_TX first; 2: extra byte with tx_done.
    task automatic frame_tail(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input int gap, input int done_delay, input int mode);
        logic [7:0] exp;
        int p0;
        exp = alu_ref(a, b, op[5:0]);
        p0  = pulse_cnt;
        send_byte(b);
        idle(gap);
        send_byte(op);
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) begin
            failures++;
            $display("FAIL exec_cycle busy=%b tx_start=%b required busy=1 tx_start=0", bus.busy, bus.tx_start);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1) begin
            failures++;
            $display("FAIL send_tx_start got=%b required=1", bus.tx_start);
        end
        checks++;
        if (bus.tx_data !== exp) begin
            failures++;
            $display("FAIL tx_data got=%h required=%h", bus.tx_data, exp);
        end
        checks++;
        if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_op !== op[5:0]) begin
            failures++;
            $display("FAIL operands got a=%h b=%h op=%h required a=%h b=%h op=%h",
                     bus.alu_a, bus.alu_b, bus.alu_op, a, b, op[5:0]);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_tx_entry tx_start=%b busy=%b required 0/1", bus.tx_start, bus.busy);
        end
        for (int i = 0; i < done_delay; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) begin
                failures++;
                $display("FAIL wait_tx_hold cycle=%0d busy=%b tx_start=%b required 1/0", i, bus.busy, bus.tx_start);
            end
        end
        if (mode == 1) begin
            send_byte(8'hAA);
            overrun_exp = 1'b1;
            checks++;
            if (bus.busy !== 1'b1 || bus.overrun !== 1'b1) begin
                failures++;
                $display("FAIL overrun_in_wait_tx busy=%b overrun=%b required 1/1", bus.busy, bus.overrun);
            end
        end
        @(negedge clk);
        bus.tx_done_tick = 1'b1;
        if (mode == 2) begin
            bus.rx_data      = 8'hAA;
            bus.rx_done_tick = 1'b1;
            overrun_exp      = 1'b1;
        end
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        bus.rx_done_tick = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.overrun !== overrun_exp) begin
            failures++;
            $display("FAIL release busy=%b overrun=%b required busy=0 overrun=%b", bus.busy, bus.overrun, overrun_exp);
        end
        checks++;
        if (pulse_cnt !== p0 + 1) begin
            failures++;
            $display("FAIL tx_start_pulses got=%0d required=%0d", pulse_cnt - p0, 1);
        end
        $display("frame a=%h b=%h op=%h mode=%0d tx_data=%h expected=%h overrun=%b",
                 a, b, op, mode, bus.tx_data, exp, bus.overrun);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int gap, input int done_delay, input int mode);
        send_byte(a);
        idle(gap);
        frame_tail(a, b, op, gap, done_delay, mode);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++;
        if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_op !== 6'h00 ||
            bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0 ||
            bus.overrun !== 1'b0 || bus.timeout_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_state a=%h b=%h op=%h tx=%h start=%b busy=%b ovr=%b tmo=%b required all 0",
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.tx_data, bus.tx_start, bus.busy,
                     bus.overrun, bus.timeout_tick);
        end
        $display("reset check done");
        reset = 1'b0;
    endtask

    task automatic test_add();
        run_frame(8'h05, 8'h03, 8'h20, 0, 2, 0);
    endtask

    task automatic test_wait_hold_wrap();
        run_frame(8'h11, 8'h22, 8'h26, 1, 50, 0);
        run_frame(8'hFF, 8'h01, 8'h20, 0, 0, 0);
    endtask

    task automatic test_overrun();
        run_frame(8'h40, 8'h02, 8'h22, 0, 3, 1);
        // A stray tx_done outside WAIT_TX must not disturb frame alignment.
        @(negedge clk);
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        run_frame(8'h10, 8'h07, 8'h20, 0, 1, 0);
    endtask

    task automatic test_collision();
        do_reset();
        run_frame(8'h0F, 8'h33, 8'h25, 0, 2, 2);
        run_frame(8'h81, 8'h02, 8'h03, 0, 0, 0);
    endtask

    task automatic test_opcode_mask();
        run_frame(8'h09, 8'h04, 8'hE2, 0, 1, 0);
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h5A);
        send_byte(8'hA5);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.tx_data !== 8'h00 ||
            bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.tx_start !== 1'b0) begin
            failures++;
            $display("FAIL async_reset a=%h b=%h tx=%h busy=%b ovr=%b start=%b required all 0",
                     bus.alu_a, bus.alu_b, bus.tx_data, bus.busy, bus.overrun, bus.tx_start);
        end
        $display("mid-frame reset applied");
        @(negedge clk);
        reset = 1'b0;
        overrun_exp = 1'b0;
        run_frame(8'h21, 8'h12, 8'h24, 0, 1, 0);
    endtask

    task automatic test_timeout();
        int seen_at;
        seen_at = -1;
        send_byte(8'h05);
`ifdef RX_TIMEOUT_EN
        for (int i = 1; i <= TMO + 20; i++) begin
            @(negedge clk);
            if (bus.timeout_tick === 1'b1 && seen_at < 0) seen_at = i;
        end
        checks++;
        if (seen_at != TMO) begin
            failures++;
            $display("FAIL timeout_tick_cycle got=%0d required=%0d", seen_at, TMO);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.alu_a !== 8'h05) begin
            failures++;
            $display("FAIL timeout_state busy=%b alu_a=%h required busy=0 alu_a=05", bus.busy, bus.alu_a);
        end
        $display("timeout pulse observed at cycle %0d", seen_at);
        run_frame(8'h07, 8'h09, 8'h20, 0, 1, 0);
`else
        for (int i = 1; i <= TMO + 50; i++) begin
            @(negedge clk);
            if (bus.timeout_tick !== 1'b0 && seen_at < 0) seen_at = i;
        end
        checks++;
        if (seen_at >= 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout tick_at=%0d busy=%b required no tick, busy=0", seen_at, bus.busy);
        end
        $display("partial frame held for %0d cycles without timeout", TMO + 50);
        frame_tail(8'h05, 8'h06, 8'h20, 0, 1, 0);
`endif
    endtask

    task automatic test_random();
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        for (int n = 0; n < 20; n++) begin
            logic [7:0] a, b, op;
            int mode;
            a    = 8'($urandom);
            b    = 8'($urandom);
            op   = ops[$urandom_range(0, 7)] | {2'($urandom), 6'h00};
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_frame(a, b, op, $urandom_range(0, 3), $urandom_range(0, 5), mode);
        end
    endtask

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = '0;
        bus.tx_done_tick = 1'b0;
        reset            = 1'b1;
        test_reset();
        test_add();
        test_wait_hold_wrap();
        test_overrun();
        test_collision();
        test_opcode_mask();
        test_reset_mid_frame();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
